// File: rtl/ldm_stm_sequencer_if.sv
// Bus bundle between the LDM/STM sequencer (master) and its pipeline, register file and memory.
interface ldm_stm_sequencer_if #(
  parameter int unsigned NREG = 15,
  parameter int unsigned DW   = 32
);
  logic            start;
  logic            is_load;
  logic [NREG-1:0] reg_list;
  logic [DW-1:0]   base_addr;
  logic            up;
  logic            pre;
  logic            wback;
  logic [3:0]      base_reg;
  logic            busy;
  logic            done;
  logic [3:0]      rf_src;
  logic [31:0]     rf_data;
  logic [3:0]      rf_dest;
  logic [31:0]     rf_result;
  logic            rf_wen;
  logic [DW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_rd;
  logic            mem_wr;
  logic [31:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    input  start, is_load, reg_list, base_addr, up, pre, wback, base_reg,
    input  rf_data, mem_rdata, mem_ready,
    output busy, done, rf_src, rf_dest, rf_result, rf_wen,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  modport slave (
    output start, is_load, reg_list, base_addr, up, pre, wback, base_reg,
    output rf_data, mem_rdata, mem_ready,
    input  busy, done, rf_src, rf_dest, rf_result, rf_wen,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Multi-register load/store sequencer: walks the register list in ascending order, one word
// access per register, then optionally writes the final base back.
module ldm_stm_sequencer #(
  parameter int unsigned NREG = 15,
  parameter int unsigned DW   = 32
) (
  input logic           clk,
  input logic           rst,
  ldm_stm_sequencer_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StWbBase, StDone} state_e;

  state_e          state_q;
  logic            is_load_q, up_q, pre_q, wback_q, base_in_list_q;
  logic [NREG-1:0] mask_q;
  logic [DW-1:0]   base_q, addr_q, final_q;
  logic [3:0]      base_reg_q, cur_q;

  logic [DW-1:0]   span;
  logic [NREG-1:0] mask_next;

  function automatic logic [3:0] lowest_set(input logic [NREG-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Byte span of the whole block: 4 * popcount(mask).
  function automatic logic [DW-1:0] block_span(input logic [NREG-1:0] m);
    logic [DW-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + DW'(m[i]);
    end
    return n << 2;
  endfunction

  assign span      = block_span(mask_q);
  assign mask_next = mask_q & ~(NREG'(1) << cur_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      is_load_q      <= 1'b0;
      up_q           <= 1'b0;
      pre_q          <= 1'b0;
      wback_q        <= 1'b0;
      base_in_list_q <= 1'b0;
      mask_q         <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      final_q        <= '0;
      base_reg_q     <= '0;
      cur_q          <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            is_load_q      <= bus.is_load;
            mask_q         <= bus.reg_list;
            base_q         <= bus.base_addr;
            up_q           <= bus.up;
            pre_q          <= bus.pre;
            wback_q        <= bus.wback;
            base_reg_q     <= bus.base_reg;
            base_in_list_q <= |(bus.reg_list & (NREG'(1) << bus.base_reg));
            state_q        <= StSetup;
          end
        end
        StSetup: begin
          final_q <= up_q ? base_q + span : base_q - span;
          // Ascending register order always maps to ascending addresses.
          unique case ({up_q, pre_q})
            2'b10:   addr_q <= base_q;
            2'b11:   addr_q <= base_q + DW'(4);
            2'b00:   addr_q <= base_q - span + DW'(4);
            default: addr_q <= base_q - span;
          endcase
          cur_q   <= lowest_set(mask_q);
          state_q <= (mask_q == '0) ? StDone : StXfer;
        end
        StXfer: begin
          if (bus.mem_ready) begin
            mask_q <= mask_next;
            addr_q <= addr_q + DW'(4);
            cur_q  <= lowest_set(mask_next);
            if (mask_next == '0) state_q <= StWbBase;
          end
        end
        StWbBase: state_q <= StDone;
        StDone:   state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.done      = (state_q == StDone);
    bus.rf_src    = '0;
    bus.rf_dest   = '0;
    bus.rf_result = '0;
    bus.rf_wen    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    case (state_q)
      StXfer: begin
        bus.rf_src   = cur_q;
        bus.mem_addr = addr_q;
        if (is_load_q) begin
          bus.mem_rd = 1'b1;
          if (bus.mem_ready) begin
            bus.rf_wen    = 1'b1;
            bus.rf_dest   = cur_q;
            bus.rf_result = bus.mem_rdata;
          end
        end else begin
          bus.mem_wr    = 1'b1;
          bus.mem_wdata = bus.rf_data;
        end
      end
      StWbBase: begin
        // A loaded base register keeps its loaded value.
        if (wback_q && !(is_load_q && base_in_list_q)) begin
          bus.rf_wen    = 1'b1;
          bus.rf_dest   = base_reg_q;
          bus.rf_result = 32'(final_q);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Randomised self-checking bench for ldm_stm_sequencer with a transaction-level reference model.
module tb_ldm_stm_sequencer;

  localparam int MAXC = 96;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rf [16];
  int n_cmp = 0;
  int n_err = 0;

  ldm_stm_sequencer_if #(.NREG(15), .DW(32)) bus ();

  ldm_stm_sequencer #(.NREG(15), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign bus.rf_data   = rf[bus.rf_src];
  assign bus.mem_rdata = mem_fn(bus.mem_addr);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, ".busy"}, 64'(bus.busy), 0);
    check_eq({tag, ".done"}, 64'(bus.done), 0);
    check_eq({tag, ".mem_rd"}, 64'(bus.mem_rd), 0);
    check_eq({tag, ".mem_wr"}, 64'(bus.mem_wr), 0);
    check_eq({tag, ".rf_wen"}, 64'(bus.rf_wen), 0);
    check_eq({tag, ".mem_addr"}, 64'(bus.mem_addr), 0);
    check_eq({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 0);
    check_eq({tag, ".rf_src"}, 64'(bus.rf_src), 0);
    check_eq({tag, ".rf_dest"}, 64'(bus.rf_dest), 0);
    check_eq({tag, ".rf_result"}, 64'(bus.rf_result), 0);
  endtask

  // Called at posedge+1 of an idle cycle; start is sampled at the next edge (cycle 0).
  task automatic run_xfer(input bit ld, input logic [14:0] list, input logic [31:0] base,
                          input bit u, input bit p, input bit wb, input logic [3:0] breg,
                          input int lows_first, input bit rnd_ready);
    logic [31:0] pre_rf [16];
    logic [31:0] exp_rf [16];
    int          regs_q[$];
    bit          rdy [MAXC];
    int          n, e, done_c, k, cnt;
    bit          hit;
    logic [31:0] start_a, fin;
    logic        e_rd, e_wr, e_wen;
    logic [31:0] e_addr, e_wd, e_res;
    logic [3:0]  e_src, e_dest;

    for (int i = 0; i < 15; i++) if (list[i]) regs_q.push_back(i);
    n   = regs_q.size();
    hit = (breg != 4'd15) && list[breg];
    fin = u ? base + 32'(4 * n) : base - 32'(4 * n);
    case ({u, p})
      2'b10:   start_a = base;
      2'b11:   start_a = base + 32'd4;
      2'b00:   start_a = base - 32'(4 * n) + 32'd4;
      default: start_a = base - 32'(4 * n);
    endcase
    for (int c = 0; c < MAXC; c++) begin
      if (c >= 60) rdy[c] = 1'b1;
      else if (c >= 2 && c - 2 < lows_first) rdy[c] = 1'b0;
      else rdy[c] = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (n == 0) begin
      e = 1;
      done_c = 2;
    end else begin
      cnt = 0;
      e = 1;
      while (cnt < n) begin
        e++;
        if (rdy[e]) cnt++;
      end
      done_c = e + 2;
    end
    for (int i = 0; i < 16; i++) begin
      pre_rf[i] = rf[i];
      exp_rf[i] = rf[i];
    end
    if (ld) for (int j = 0; j < n; j++) exp_rf[regs_q[j]] = mem_fn(start_a + 32'(4 * j));
    if (n > 0 && wb && !(ld && hit)) exp_rf[breg] = fin;

    bus.start     = 1'b1;
    bus.is_load   = ld;
    bus.reg_list  = list;
    bus.base_addr = base;
    bus.up        = u;
    bus.pre       = p;
    bus.wback     = wb;
    bus.base_reg  = breg;
    bus.mem_ready = rdy[0];
    @(posedge clk);
    #1;
    for (int c = 1; c <= done_c + 1; c++) begin
      // Inputs other than mem_ready must be ignored once the transfer is running.
      bus.start     = (c <= done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.reg_list  = 15'($urandom());
      bus.base_addr = $urandom();
      bus.is_load   = 1'($urandom_range(0, 1));
      bus.up        = 1'($urandom_range(0, 1));
      bus.wback     = 1'($urandom_range(0, 1));
      bus.base_reg  = 4'($urandom_range(0, 15));
      bus.mem_ready = rdy[c];
      #3;
      e_rd = 0; e_wr = 0; e_wen = 0; e_addr = 0; e_wd = 0; e_res = 0; e_src = 0; e_dest = 0;
      if (n > 0 && c >= 2 && c <= e) begin
        k = 0;
        for (int j = 2; j < c; j++) if (rdy[j]) k++;
        e_addr = start_a + 32'(4 * k);
        e_src  = 4'(regs_q[k]);
        if (ld) begin
          e_rd = 1;
          if (rdy[c]) begin
            e_wen  = 1;
            e_dest = e_src;
            e_res  = mem_fn(e_addr);
          end
        end else begin
          e_wr = 1;
          e_wd = pre_rf[regs_q[k]];
        end
      end else if (n > 0 && c == e + 1 && wb && !(ld && hit)) begin
        e_wen  = 1;
        e_dest = breg;
        e_res  = fin;
      end
      check_eq($sformatf("c%0d.busy", c), 64'(bus.busy), 64'(c <= done_c));
      check_eq($sformatf("c%0d.done", c), 64'(bus.done), 64'(c == done_c));
      check_eq($sformatf("c%0d.mem_rd", c), 64'(bus.mem_rd), 64'(e_rd));
      check_eq($sformatf("c%0d.mem_wr", c), 64'(bus.mem_wr), 64'(e_wr));
      check_eq($sformatf("c%0d.mem_addr", c), 64'(bus.mem_addr), 64'(e_addr));
      check_eq($sformatf("c%0d.mem_wdata", c), 64'(bus.mem_wdata), 64'(e_wd));
      check_eq($sformatf("c%0d.rf_src", c), 64'(bus.rf_src), 64'(e_src));
      check_eq($sformatf("c%0d.rf_wen", c), 64'(bus.rf_wen), 64'(e_wen));
      check_eq($sformatf("c%0d.rf_dest", c), 64'(bus.rf_dest), 64'(e_dest));
      check_eq($sformatf("c%0d.rf_result", c), 64'(bus.rf_result), 64'(e_res));
      // Register file commits on the falling edge that follows this sample point.
      if (bus.rf_wen === 1'b1) rf[bus.rf_dest] = bus.rf_result;
      if (c <= done_c) begin
        @(posedge clk);
        #1;
      end
    end
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) check_eq($sformatf("rf[%0d]", i), 64'(rf[i]), 64'(exp_rf[i]));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [14:0] lst;
    bus.start = 0; bus.is_load = 0; bus.reg_list = 0; bus.base_addr = 0; bus.up = 0;
    bus.pre = 0; bus.wback = 0; bus.base_reg = 0; bus.mem_ready = 0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom();
    #3;
    check_all_zero("reset");
    next_cycle();
    rst = 1'b0;

    next_cycle(); run_xfer(0, 15'h002A, 32'h100, 1, 0, 1, 4'd13, 0, 0);  // STM IA wb
    next_cycle(); run_xfer(1, 15'h0005, 32'h200, 0, 1, 1, 4'd4, 0, 0);   // LDM DB wb
    next_cycle(); run_xfer(1, 15'h0080, 32'h040, 1, 1, 0, 4'd0, 2, 0);   // LDM IB wait
    next_cycle(); run_xfer(1, 15'h0014, 32'h500, 1, 0, 1, 4'd2, 0, 0);   // base in list
    next_cycle(); run_xfer(0, 15'h0000, 32'h700, 1, 0, 1, 4'd3, 0, 0);   // empty
    next_cycle(); run_xfer(0, 15'h0108, 32'h600, 0, 0, 1, 4'd3, 0, 0);   // STM DA base in list
    next_cycle(); run_xfer(0, 15'h4801, 32'hFFFF_FFF8, 1, 0, 1, 4'd15, 0, 0);  // wrap up
    next_cycle(); run_xfer(1, 15'h0007, 32'h0000_0004, 0, 1, 1, 4'd9, 0, 1);   // wrap down

    // Reset during the second XFER of a 4-register STM.
    next_cycle();
    bus.start = 1; bus.is_load = 0; bus.reg_list = 15'h001E; bus.base_addr = 32'h300;
    bus.up = 1; bus.pre = 0; bus.wback = 1; bus.base_reg = 4'd5; bus.mem_ready = 1;
    next_cycle();
    bus.start = 0;
    next_cycle();
    next_cycle();
    #3;
    check_eq("rst.pre.mem_wr", 64'(bus.mem_wr), 1);
    check_eq("rst.pre.mem_addr", 64'(bus.mem_addr), 64'h304);
    check_eq("rst.pre.mem_wdata", 64'(bus.mem_wdata), 64'(rf[2]));
    #1 rst = 1'b1;
    #1;
    check_all_zero("rst.mid");
    next_cycle();
    check_all_zero("rst.hold");
    rst = 1'b0;
    run_xfer(0, 15'h0001, 32'h0, 1, 0, 0, 4'd0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      lst = ($urandom_range(0, 3) == 0) ? 15'(1 << $urandom_range(0, 14)) : 15'($urandom());
      if ($urandom_range(0, 9) == 0) lst = '0;
      next_cycle();
      run_xfer(1'($urandom_range(0, 1)), lst, $urandom() & 32'hFFFF_FFFC,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
# ldm_stm_sequencer

Multi-register load/store sequencer (ARM LDM/STM: IA/IB/DA/DB, optional base writeback). It drives one register-file read port and the register-file write port, and issues one word-wide data-memory access per selected register. It sits beside the memory stage and holds the pipeline via `busy` while a block transfer runs.

## Interface
- `NREG`, 15: number of architectural registers, R0..R14. Sets the `reg_list` width.
- `DW`, 32: data and address width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transfer; sampled only in IDLE.
- `is_load`  in  1  1 = LDM, 0 = STM; captured at start.
- `reg_list`  in  NREG  bit i selects Ri; captured at start.
- `base_addr`  in  DW  base address value; captured at start.
- `up`  in  1  1 = increment, 0 = decrement.
- `pre`  in  1  1 = before, 0 = after.
- `wback`  in  1  write the final base to `base_reg`.
- `base_reg`  in  4  index of the base register.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `rf_src`  out  4  register-file read index.
- `rf_data`  in  32  register-file read data for `rf_src`.
- `rf_dest`  out  4  register-file write index.
- `rf_result`  out  32  register-file write data.
- `rf_wen`  out  1  register-file write enable; the register file writes on the falling `clk` edge.
- `mem_addr`  out  DW  word address.
- `mem_wdata`  out  32  store data.
- `mem_rd`  out  1  read request.
- `mem_wr`  out  1  write request.
- `mem_rdata`  in  32  load data, valid when `mem_ready`=1.
- `mem_ready`  in  1  completes the current request at this rising edge.

## Operation
- **States:** IDLE, SETUP, XFER, WB_BASE, DONE.
- **IDLE:** when `start`=1, capture all inputs and go to SETUP.
- **SETUP** (1 cycle): compute N = popcount(`reg_list`) and the start address.
  - IA: start = base.
  - IB: start = base+4.
  - DA: start = base−4N+4.
  - DB: start = base−4N.
  - Final base = `up` ? base+4N : base−4N. All arithmetic is modulo 2^DW.
  - If N=0, go to DONE; otherwise load the lowest set bit into `cur` and go to XFER.
- **XFER:** `mem_addr` = current address and `rf_src` = `cur`.
  - STM: `mem_wr`=1 and `mem_wdata` = `rf_data`.
  - LDM: `mem_rd`=1.
  - Address and data are held stable until `mem_ready`=1.
  - On the ready cycle (LDM only), `rf_wen`=1, `rf_dest`=`cur`, `rf_result`=`mem_rdata`. This is combinational in the same cycle.
  - At the ready edge: clear bit `cur` from the remaining mask and add 4 to the address. Registers are always processed in ascending order, so the lowest register lands at the lowest address.
  - When no bits remain, go to WB_BASE.
- **WB_BASE** (1 cycle): if `wback` and not (LDM with `base_reg` in the list), set `rf_wen`=1, `rf_dest`=`base_reg`, `rf_result`=final base. Then go to DONE.
- **Base in list:**
  - LDM: the loaded value wins and the base write is suppressed.
  - STM: the original base value is stored.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- `start` is ignored outside IDLE.

## Timing
- **Reset values** (async): state = IDLE; `busy`, `done`, `rf_wen`, `mem_rd`, `mem_wr` = 0; `rf_src`, `rf_dest`, `rf_result`, `mem_addr`, `mem_wdata` = 0.
- **Outputs:** `mem_*`, `rf_*` and `done` are 0 in every state and cycle not listed above.
- **Latency**, start sampled at edge 0, `mem_ready` tied high:
  - SETUP is cycle 1.
  - XFER is cycles 2..N+1.
  - WB_BASE is cycle N+2.
  - DONE is cycle N+3, and `busy` falls after it.
- Each low cycle of `mem_ready` adds one cycle.
- **N=0:** DONE at cycle 2; no memory or register-file activity.
- **Reset mid-operation:** abort immediately with no further requests. A new `start` is accepted at the first edge after `rst` falls.
- **Address wrap:** address wrap-around past 0xFFFFFFFC is legal and wraps mod 2^32.

## Test plan
- **STM IA with writeback:** STM IA, list {R1,R3,R5}, base 0x100, `wback`, `base_reg`=13, ready tied high → writes at 0x100/0x104/0x108 with R1/R3/R5 data; R13 ← 0x10C in WB_BASE; `done` at cycle 6.
- **LDM DB with writeback:** LDM DB, list {R0,R2}, base 0x200, `wback`, `base_reg`=4 → reads 0x1F8→R0 and 0x1FC→R2, each with `rf_wen` in its ready cycle; R4 ← 0x1F8.
- **Wait states:** LDM IB, list {R7}, base 0x40, `mem_ready` low for 2 cycles → `mem_addr`=0x44 held for 3 cycles; `rf_wen` only in the third; `done` at cycle 6.
- **LDM with base in list:** LDM IA, list {R2,R4}, `base_reg`=2, `wback` → R2 gets the loaded value; no `rf_wen` in WB_BASE.
- **Empty list:** `reg_list`=0 → `done` at cycle 2; `mem_rd`/`mem_wr`/`rf_wen` never asserted.
- **Reset mid-transfer:** `rst` pulsed during the 2nd XFER of a 4-register STM → all outputs 0 at once, state IDLE; a following STM IA {R0} at 0x0 completes normally.
